// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: receive-side checker for an asynchronous ripple
// up/down counter. It synchronises the raw flip-flop outputs, lets each value
// through only after it has been stable for a while (so ripple transients are
// dropped), publishes every settled count and classifies each settled step as
// up, down or illegal.
module ripple_count_monitor #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             m_exp,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count_out,
  output logic             count_valid,
  output logic             locked,
  output logic             dir_up,
  output logic             dir_down,
  output logic             step_err,
  output logic             dir_mismatch,
  output logic [ERR_W-1:0] err_count
);

  localparam int SCW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_d;
  // Valid flags travel alongside the data so values left over from reset are
  // never mistaken for a real sample: the first lock after reset is always a
  // value that was actually seen on q_in.
  logic             vld1;
  logic             vld2;
  logic             vld_d;
  logic [SCW-1:0]   stab_cnt;
  logic             same;
  logic             accept;
  logic [WIDTH-1:0] delta;
  logic             is_up;
  logic             is_down;
  logic             is_err;
  state_t           state;

  // Two-flop synchroniser per bit, plus a valid flag that fills after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
    end else begin
      sync1 <= q_in;
      s     <= sync1;
      vld1  <= 1'b1;
      vld2  <= vld1;
    end
  end

  // Stability filter: count how long the synchronised value has held still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d      <= '0;
      vld_d    <= 1'b0;
      stab_cnt <= '0;
    end else begin
      s_d   <= s;
      vld_d <= vld2;
      if (!vld2) begin
        stab_cnt <= '0;
      end else if (!same) begin
        stab_cnt <= SCW'(1);
      end else if (stab_cnt < SCW'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + SCW'(1);
      end
    end
  end

  // Acceptance fires exactly once, on the edge the run length reaches the target.
  always_comb begin
    same   = vld_d && (s == s_d);
    accept = 1'b0;
    if (vld2) begin
      if (same) begin
        accept = (stab_cnt == SCW'(STABLE_CYCLES - 1));
      end else begin
        accept = (STABLE_CYCLES == 1);
      end
    end
    delta   = s - count_out;
    is_up   = (delta == WIDTH'(1));
    is_down = (delta == {WIDTH{1'b1}});
    is_err  = accept && (state == LOCKED) && (s != count_out) && !is_up && !is_down;
  end

  // Lock/step FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= UNLOCKED;
      count_out    <= '0;
      count_valid  <= 1'b0;
      locked       <= 1'b0;
      dir_up       <= 1'b0;
      dir_down     <= 1'b0;
      step_err     <= 1'b0;
      dir_mismatch <= 1'b0;
    end else begin
      count_valid  <= 1'b0;
      dir_up       <= 1'b0;
      dir_down     <= 1'b0;
      step_err     <= 1'b0;
      dir_mismatch <= 1'b0;
      if (accept) begin
        case (state)
          UNLOCKED: begin
            count_out   <= s;
            count_valid <= 1'b1;
            locked      <= 1'b1;
            state       <= LOCKED;
          end
          LOCKED: begin
            // A transient that settles back on the old value is not a step.
            if (s != count_out) begin
              count_out    <= s;
              count_valid  <= 1'b1;
              dir_up       <= is_up;
              dir_down     <= is_down;
              step_err     <= !is_up && !is_down;
              dir_mismatch <= (is_up && m_exp) || (is_down && !m_exp);
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  // Saturating illegal-step counter; a clear coinciding with an error leaves 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (is_err) begin
      if (clr_err) begin
        err_count <= ERR_W'(1);
      end else if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
    end else if (clr_err) begin
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Testbench for ripple_count_monitor: directed scenarios plus randomized
// stimulus, checked every cycle against a behavioural model built from a
// sample history of q_in.
module tb_ripple_count_monitor;
  localparam int W      = 3;
  localparam int SC     = 2;
  localparam int EW     = 8;
  localparam int MOD    = 1 << W;
  localparam int ERRMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  q_in = '0;
  logic          m_exp = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  count_out;
  logic          count_valid;
  logic          locked;
  logic          dir_up;
  logic          dir_down;
  logic          step_err;
  logic          dir_mismatch;
  logic [EW-1:0] err_count;

  ripple_count_monitor #(.WIDTH(W), .STABLE_CYCLES(SC), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .m_exp(m_exp), .clr_err(clr_err),
    .count_out(count_out), .count_valid(count_valid), .locked(locked),
    .dir_up(dir_up), .dir_down(dir_down), .step_err(step_err),
    .dir_mismatch(dir_mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state. hist holds q_in as seen at each clock edge;
  // -1 marks "no sample since reset".
  int hist[$];
  bit m_locked, m_valid, m_up, m_down, m_err, m_mis;
  int m_count, m_errcnt;

  // Pulse counters observed on the DUT.
  int n_valid = 0, n_up = 0, n_down = 0, n_err = 0, n_mis = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    repeat (SC + 3) hist.push_back(-1);
    m_locked = 0; m_valid = 0; m_up = 0; m_down = 0; m_err = 0; m_mis = 0;
    m_count = 0; m_errcnt = 0;
  endtask

  // A value is accepted at edge k when q_in sampled at edges k-2 .. k-1-SC all
  // agree and the sample just before that run differs (or does not exist).
  task automatic model_step();
    int last, v, d;
    bit acc;
    hist.push_back(int'(q_in));
    void'(hist.pop_front());
    last = hist.size() - 1;
    v = hist[last - 2];
    acc = (v >= 0);
    for (int j = 3; j <= SC + 1; j++)
      if (hist[last - j] != v) acc = 0;
    if (hist[last - SC - 2] == v) acc = 0;
    m_valid = 0; m_up = 0; m_down = 0; m_err = 0;
    if (acc) begin
      if (!m_locked) begin
        m_locked = 1; m_count = v; m_valid = 1;
      end else if (v != m_count) begin
        d = (v - m_count + MOD) % MOD;
        m_valid = 1;
        if (d == 1) m_up = 1;
        else if (d == MOD - 1) m_down = 1;
        else m_err = 1;
        m_count = v;
      end
    end
    m_mis = (m_up && m_exp) || (m_down && !m_exp);
    if (m_err) m_errcnt = clr_err ? 1 : ((m_errcnt + 1 > ERRMAX) ? ERRMAX : m_errcnt + 1);
    else if (clr_err) m_errcnt = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (count_valid) n_valid++;
      if (dir_up) n_up++;
      if (dir_down) n_down++;
      if (step_err) n_err++;
      if (dir_mismatch) n_mis++;
      chk("count_out",    int'(count_out),    rst ? 0 : m_count);
      chk("count_valid",  int'(count_valid),  rst ? 0 : int'(m_valid));
      chk("locked",       int'(locked),       rst ? 0 : int'(m_locked));
      chk("dir_up",       int'(dir_up),       rst ? 0 : int'(m_up));
      chk("dir_down",     int'(dir_down),     rst ? 0 : int'(m_down));
      chk("step_err",     int'(step_err),     rst ? 0 : int'(m_err));
      chk("dir_mismatch", int'(dir_mismatch), rst ? 0 : int'(m_mis));
      chk("err_count",    int'(err_count),    rst ? 0 : m_errcnt);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold(input int v, input int n);
    q_in = W'(v);
    step(n);
  endtask

  int b_valid, b_up, b_down, b_err, b_mis;

  task automatic snap();
    b_valid = n_valid; b_up = n_up; b_down = n_down; b_err = n_err; b_mis = n_mis;
  endtask

  initial begin
    // 1. Lock on 0
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    snap();
    hold(0, 10);
    chk("lock_valid_pulses", n_valid - b_valid, 1);
    chk("lock_count", int'(count_out), 0);
    chk("lock_locked", int'(locked), 1);
    chk("lock_dir_pulses", (n_up - b_up) + (n_down - b_down) + (n_err - b_err), 0);

    // 2. Up with wrap
    m_exp = 1'b0;
    snap();
    for (int i = 1; i <= 8; i++) hold(i % MOD, 10);
    chk("up_pulses", n_up - b_up, 8);
    chk("up_valid_pulses", n_valid - b_valid, 8);
    chk("up_err_count", int'(err_count), 0);
    chk("up_mismatch", n_mis - b_mis, 0);

    // 3. Down with wrap, then a mismatching down step
    m_exp = 1'b1;
    snap();
    hold(7, 10); hold(6, 10); hold(5, 10);
    chk("down_pulses", n_down - b_down, 3);
    chk("down_count", int'(count_out), 5);
    m_exp = 1'b0;
    snap();
    hold(4, 10);
    chk("mismatch_down", n_down - b_down, 1);
    chk("mismatch_pulse", n_mis - b_mis, 1);

    // 4. Ripple rejection 3 -> (2) -> (0) -> 4
    hold(3, 10);
    snap();
    hold(2, 1); hold(0, 1); hold(4, 10);
    chk("ripple_valid", n_valid - b_valid, 1);
    chk("ripple_count", int'(count_out), 4);
    chk("ripple_up", n_up - b_up, 1);
    chk("ripple_err", n_err - b_err, 0);

    // 5. Illegal steps, clear collision, saturation
    hold(2, 10);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    hold(5, 10);
    chk("illegal_err_count", int'(err_count), 1);
    chk("illegal_count", int'(count_out), 5);
    q_in = 3'd0;
    step(3);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    step(6);
    chk("clr_collision_err_count", int'(err_count), 1);
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 5 : 0, 4);
    chk("saturated_err_count", int'(err_count), 255);

    // 6. Asynchronous reset mid-cycle, relock on 6
    hold(5, 10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_count_out", int'(count_out), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_pulses", int'(count_valid) + int'(dir_up) + int'(dir_down) + int'(step_err) + int'(dir_mismatch), 0);
    q_in = 3'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    snap();
    step(10);
    chk("relock_count", int'(count_out), 6);
    chk("relock_locked", int'(locked), 1);
    chk("relock_valid", n_valid - b_valid, 1);
    chk("relock_dir", (n_up - b_up) + (n_down - b_down) + (n_err - b_err), 0);

    // 7. Randomized values, hold times, mode and clears against the model
    for (int i = 0; i < 400; i++) begin
      int n;
      q_in  = W'($urandom_range(0, MOD - 1));
      m_exp = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int c = 0; c < n; c++) begin
        clr_err = ($urandom_range(0, 7) == 0);
        step(1);
      end
    end
    clr_err = 1'b0;
    step(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Receive-side checker for the asynchronous ripple up/down counter. It samples the counter's unsynchronised flip-flop outputs in the system clock domain and suppresses ripple transients.
- Publishes each settled count value with a one-cycle valid strobe.
- Classifies every settled step as up, down or illegal.
- Compares the step direction against the expected mode and counts illegal steps for the bench and for debug logic.

Parameters:
- WIDTH, 3, counter width in bits (qc..qa); must be >= 2.
- STABLE_CYCLES, 2, consecutive clock edges the synchronised value must stay unchanged before it is accepted; must be >= 1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- q_in  input  WIDTH  raw counter outputs, asynchronous to clk; bit0 = qa.
- m_exp  input  1  expected mode, synchronous to clk: 0 = up, 1 = down.
- clr_err  input  1  synchronous clear of err_count.
- count_out  output  WIDTH  last accepted count value.
- count_valid  output  1  one-cycle pulse when count_out updates.
- locked  output  1  high once a first value has been accepted.
- dir_up  output  1  one-cycle pulse: accepted step was +1 mod 2^WIDTH.
- dir_down  output  1  one-cycle pulse: accepted step was -1 mod 2^WIDTH.
- step_err  output  1  one-cycle pulse: accepted step was neither +1 nor -1.
- dir_mismatch  output  1  one-cycle pulse: legal step whose direction differs from m_exp.
- err_count  output  ERR_W  saturating count of step_err pulses.

Behaviour:
- Reset (async, rst=1):
  - Both synchroniser stages, stability counter and candidate register clear to 0.
  - State goes to UNLOCKED.
  - All outputs go to 0 immediately and are held at 0 while rst=1.
- Synchroniser:
  - Per-bit two-flop chain; its output is s.
  - Latency is 2 edges, and sync flops are not reset-bypassed.
- Stability filter:
  - Register the previous s as s_d.
  - If s != s_d, stab_cnt <= 1. Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - Acceptance fires on the edge where stab_cnt reaches STABLE_CYCLES, once per stable run.
  - A value shorter than STABLE_CYCLES edges is discarded.
- Latency: q_in settled before edge N gives outputs updated after edge N+1+STABLE_CYCLES. With default parameters, acceptance and the output pulses appear 4 clocks after settle.
- FSM state UNLOCKED:
  - On acceptance of v: count_out <= v, count_valid=1, locked <= 1, go to LOCKED.
  - No direction pulses are generated.
- FSM state LOCKED, on acceptance of v with previous count_out p:
  - v == p: no pulse and no update. This covers a glitch that returns to the same value.
  - v == p+1 mod 2^WIDTH: dir_up=1.
  - v == p-1 mod 2^WIDTH: dir_down=1.
  - Otherwise: step_err=1.
  - In every case except v == p: count_out <= v and count_valid=1.
  - Wrap-around is legal in both directions: 7->0 is up, 0->7 is down.
- dir_mismatch: equals (dir_up & m_exp) | (dir_down & ~m_exp), sampled on the accept edge. It is never asserted with step_err.
- err_count:
  - Increments on step_err and saturates at 2^ERR_W-1.
  - clr_err=1 sets it to 0.
  - If clr_err and step_err occur in the same cycle, the result is 1.
- Exclusivity: at most one of dir_up, dir_down and step_err is high in any cycle. Every pulse lasts exactly 1 cycle.
- Back-to-back steps: there is no throughput limit beyond the filter. Each new value needs STABLE_CYCLES edges of stability.
- Reset mid-operation: all state is lost and the block returns to UNLOCKED. The first value after reset is treated as a fresh lock with no direction evaluated.

Test Plan:
1. Lock: apply and release rst, then hold q_in=3'b000 with a 10 ns clock -> 4 clocks after the sync chain has flushed, count_valid pulses once, count_out=0, locked=1, and no dir_up, dir_down or step_err pulse.
2. Up with wrap: m_exp=0, q_in steps 0,1,...,7,0, each value held 10 clocks -> 8 dir_up pulses including the 7->0 wrap, 8 count_valid pulses, err_count=0, dir_mismatch never asserted.
3. Down with wrap: m_exp=1, q_in steps 0->7->6->5 -> 3 dir_down pulses with count_out ending at 5. Then set m_exp=0 and step 5->4 -> dir_down together with dir_mismatch.
4. Ripple rejection: locked at 3, q_in goes 011 -> 010 for 1 clock -> 000 for 1 clock -> 100 held -> exactly one count_valid, count_out=4, dir_up=1, step_err never asserted.
5. Illegal steps: locked at 2, apply q_in=5 -> step_err, err_count=1, count_out=5.
   - Assert clr_err in the same cycle as the next illegal step (5->0) -> err_count=1.
   - Apply 300 further illegal steps with ERR_W=8 -> err_count saturates at 255.
6. Reset mid-run: locked at 5, assert rst for 3 clocks asynchronously mid-cycle -> all outputs 0 immediately, locked=0. After release with q_in=6 held -> relock at count_out=6 with count_valid and no direction pulse.
